fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Control block for the dual-issue instruction fetch stage. Owns the fetch PC pair, selects the next PC (sequential, JALR, branch or jump target) and sequences fetch through reset, load-use stalls, memory wait states and redirect flushes. Drives the instruction memory read enable, per-slot valid flags to decode, and a squash pulse that kills the pair already in flight. Sits between the execute-stage redirect logic and the instruction memory/decode boundary.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset; bits [2:0] must be zero
- CLK  in  1  system clock, all state updates on rising edge
- EXT_RESET  in  1  synchronous, active-high reset
- pc_source  in  2  0 = sequential, 1 = jalr_pc, 2 = branch_pc, 3 = jump_pc; nonzero = redirect request this cycle
- jalr_pc, branch_pc, jump_pc  in  32 each  redirect targets
- ld_haz  in  1  decode cannot accept; hold current pair
- mem_ready  in  1  instruction memory returns the pair this cycle
- fetch_pc_0  out  32  slot-0 address
- fetch_pc_1  out  32  slot-1 address, always fetch_pc_0 + 4
- fetch_valid_0, fetch_valid_1  out  1 each  slot carries a live instruction
- memRead1  out  1  instruction memory read enable
- squash  out  1  kill any instruction pair already in decode
- bubble_count  out  16  saturating count of cycles with no valid pair delivered

## Operation
- State register: RST_WAIT, FETCH, HOLD, FLUSH. Single PC register `pc`; fetch_pc_0 = pc, fetch_pc_1 = pc + 4 (32-bit wrap).
- RST_WAIT: entered on EXT_RESET; pc = RESET_PC; memRead1 = 0, valids = 0, squash = 0. Always → FETCH next cycle.
- FETCH: memRead1 = 1. Valids = 1 only when mem_ready = 1. Transitions (priority order): redirect → FLUSH; !mem_ready or ld_haz → HOLD (pc unchanged); else pc += 8, stay FETCH.
- HOLD: pc unchanged, memRead1 = 1, valids = mem_ready. Redirect → FLUSH; mem_ready & !ld_haz → pc += 8, FETCH; else stay HOLD.
- FLUSH: memRead1 = 0, valids = 0, squash = 1. pc already holds target. Another redirect here → reload pc with new target, stay FLUSH one more cycle; else → FETCH.
- Redirect (any state except RST_WAIT): pc ← selected target with bits [1:0] forced to 0. Target need not be 8-byte aligned; pair is always {t, t+4}. Redirect beats ld_haz and mem_ready.
- Redirect inputs ignored in RST_WAIT.
- bubble_count: increments each cycle after reset where fetch_valid_0 = 0; saturates at 16'hFFFF; cleared by EXT_RESET.
- fetch_valid_0 and fetch_valid_1 are always equal.

## Timing
- All outputs are functions of registered state plus mem_ready (valids only); no combinational path from pc_source, targets or ld_haz to any output.
- Reset: cycle with EXT_RESET high → next cycle RST_WAIT: pc = RESET_PC, all outputs 0, bubble_count = 0. EXT_RESET mid-flush or mid-hold overrides everything.
- First fetch: FETCH with fetch_pc_0 = RESET_PC on 2nd cycle after reset release.
- Sequential throughput: one pair per cycle with mem_ready = 1, ld_haz = 0.
- Redirect at cycle N → cycle N+1 FLUSH (squash = 1) → cycle N+2 FETCH with fetch_pc_0 = target. Redirect-to-fetch latency 2 cycles, exactly one bubble.
- ld_haz at cycle N → pc at N+1 equals pc at N.
- pc = 32'hFFFF_FFF8 advancing → 32'h0000_0000 (wrap, no flag).

## Test plan
- Reset: EXT_RESET high 2 cycles, RESET_PC = 0 → RST_WAIT outputs 0; next cycle fetch_pc_0 = 0, fetch_pc_1 = 4, memRead1 = 1; then 8/12, 16/20 each cycle, bubble_count = 1.
- Stall: ld_haz high 3 cycles while fetch_pc_0 = 0x10 → pc holds 0x10 for 3 extra cycles, valids stay 1, then 0x18.
- Memory wait: mem_ready low 2 cycles at pc 0x20 → valids 0 for 2 cycles, pc held, bubble_count +2, then 0x20 delivered once with valids 1.
- Branch redirect: pc_source = 2, branch_pc = 0x104 at cycle N → N+1 squash = 1, valids 0; N+2 fetch_pc_0 = 0x104, fetch_pc_1 = 0x108; N+3 0x10C.
- Redirect priority: pc_source = 3, jump_pc = 0x203, ld_haz = 1, mem_ready = 0 same cycle → FLUSH, then fetch_pc_0 = 0x200; back-to-back jalr redirect during FLUSH to 0x400 → second FLUSH, then 0x400.
- Wrap and saturation: RESET_PC = 32'hFFFF_FFF8 → pairs FFFF_FFF8/FFFF_FFFC then 0/4; hold mem_ready low 70000 cycles → bubble_count = 16'hFFFF.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Purpose : dual-issue fetch control; owns the PC pair, picks the next PC, sequences reset/stall/wait/flush.
// Latency : redirect -> one FLUSH cycle (squash) -> target pair fetched 2 cycles after the request.
// Backpr. : ld_haz or !mem_ready holds the current pair (HOLD); redirect overrides both.
//
// Ports:
//   CLK, EXT_RESET               clock, synchronous active-high reset
//   pc_source                    0 sequential, 1 jalr_pc, 2 branch_pc, 3 jump_pc (nonzero = redirect)
//   jalr_pc/branch_pc/jump_pc    redirect targets
//   ld_haz, mem_ready            decode hold request, instruction memory data-valid
//   fetch_pc_0/1                 slot addresses (pc, pc+4)
//   fetch_valid_0/1              slot carries a live instruction (always equal)
//   memRead1                     instruction memory read enable
//   squash                       kill the pair already in decode
//   bubble_count                 saturating count of cycles without a valid pair
//
// RESET_PC must have bits [2:0] clear.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        EXT_RESET,
  input  logic [1:0]  pc_source,
  input  logic [31:0] jalr_pc,
  input  logic [31:0] branch_pc,
  input  logic [31:0] jump_pc,
  input  logic        ld_haz,
  input  logic        mem_ready,
  output logic [31:0] fetch_pc_0,
  output logic [31:0] fetch_pc_1,
  output logic        fetch_valid_0,
  output logic        fetch_valid_1,
  output logic        memRead1,
  output logic        squash,
  output logic [15:0] bubble_count
);

  localparam logic [1:0] RST_WAIT = 2'd0;
  localparam logic [1:0] FETCH    = 2'd1;
  localparam logic [1:0] HOLD     = 2'd2;
  localparam logic [1:0] FLUSH    = 2'd3;

  logic [1:0]  state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] target;
  logic        redirect;
  logic        fetching;

  assign redirect = (pc_source != 2'd0);

  // Targets are word-aligned only; the pair is always {t, t+4} even if t is not 8-byte aligned.
  always_comb begin
    target = 32'h0;
    case (pc_source)
      2'd1:    target = jalr_pc;
      2'd2:    target = branch_pc;
      2'd3:    target = jump_pc;
      default: target = 32'h0;
    endcase
    target = target & 32'hFFFF_FFFC;
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    case (state)
      RST_WAIT: begin
        // Redirects are ignored while coming out of reset.
        state_nxt = FETCH;
        pc_nxt    = RESET_PC;
      end
      FETCH: begin
        if (redirect) begin
          state_nxt = FLUSH;
          pc_nxt    = target;
        end else if (!mem_ready || ld_haz) begin
          state_nxt = HOLD;
        end else begin
          pc_nxt = pc + 32'd8;
        end
      end
      HOLD: begin
        if (redirect) begin
          state_nxt = FLUSH;
          pc_nxt    = target;
        end else if (mem_ready && !ld_haz) begin
          state_nxt = FETCH;
          pc_nxt    = pc + 32'd8;
        end
      end
      default: begin
        // FLUSH: pc already holds the target; a new redirect reloads it and extends the flush.
        if (redirect) begin
          state_nxt = FLUSH;
          pc_nxt    = target;
        end else begin
          state_nxt = FETCH;
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (EXT_RESET) begin
      state        <= RST_WAIT;
      pc           <= RESET_PC;
      bubble_count <= 16'h0000;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (!fetch_valid_0 && (bubble_count != 16'hFFFF))
        bubble_count <= bubble_count + 16'd1;
    end
  end

  // Outputs depend only on registered state, plus mem_ready for the valids.
  assign fetching      = (state == FETCH) || (state == HOLD);
  assign fetch_pc_0    = pc;
  assign fetch_pc_1    = pc + 32'd4;
  assign memRead1      = fetching;
  assign fetch_valid_0 = fetching && mem_ready;
  assign fetch_valid_1 = fetch_valid_0;
  assign squash        = (state == FLUSH);

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

  logic        clk;
  logic        rst;
  logic [1:0]  pc_source;
  logic [31:0] jalr_pc, branch_pc, jump_pc;
  logic        ld_haz, mem_ready;

  logic [31:0] fetch_pc_0, fetch_pc_1;
  logic        fetch_valid_0, fetch_valid_1, memRead1, squash;
  logic [15:0] bubble_count;

  logic [31:0] w_pc_0, w_pc_1;
  logic        w_valid_0, w_valid_1, w_rd, w_squash;
  logic [15:0] w_bubble;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_sequencer #(.RESET_PC(32'h0000_0000)) dut (
    .CLK(clk), .EXT_RESET(rst), .pc_source(pc_source),
    .jalr_pc(jalr_pc), .branch_pc(branch_pc), .jump_pc(jump_pc),
    .ld_haz(ld_haz), .mem_ready(mem_ready),
    .fetch_pc_0(fetch_pc_0), .fetch_pc_1(fetch_pc_1),
    .fetch_valid_0(fetch_valid_0), .fetch_valid_1(fetch_valid_1),
    .memRead1(memRead1), .squash(squash), .bubble_count(bubble_count)
  );

  fetch_sequencer #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
    .CLK(clk), .EXT_RESET(rst), .pc_source(pc_source),
    .jalr_pc(jalr_pc), .branch_pc(branch_pc), .jump_pc(jump_pc),
    .ld_haz(ld_haz), .mem_ready(mem_ready),
    .fetch_pc_0(w_pc_0), .fetch_pc_1(w_pc_1),
    .fetch_valid_0(w_valid_0), .fetch_valid_1(w_valid_1),
    .memRead1(w_rd), .squash(w_squash), .bubble_count(w_bubble)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [1:0]  src;
    logic [31:0] tgt;
    logic        lh;
    logic        mr;
    logic [31:0] pc0;
    logic        vld;
    logic        rd;
    logic        sq;
    logic [15:0] bub;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    rst       = v.rst;
    pc_source = v.src;
    // Non-selected targets carry junk so a wrong select is visible.
    jalr_pc   = (v.src == 2'd1) ? v.tgt : 32'h1111_1110;
    branch_pc = (v.src == 2'd2) ? v.tgt : 32'h2222_2220;
    jump_pc   = (v.src == 2'd3) ? v.tgt : 32'h3333_3330;
    ld_haz    = v.lh;
    mem_ready = v.mr;
  endtask

  initial begin
    vec_t e;
    //                rst src tgt           lh   mr  | pc0           vld  rd   sq   bub
    vecs.push_back('{1'b0, 2'd0, 32'h000, 1'b0, 1'b1, 32'h000, 1'b0, 1'b0, 1'b0, 16'd0});  // RST_WAIT
    vecs.push_back('{1'b0, 2'd0, 32'h000, 1'b0, 1'b1, 32'h000, 1'b1, 1'b1, 1'b0, 16'd1});  // first fetch
    vecs.push_back('{1'b0, 2'd0, 32'h000, 1'b0, 1'b1, 32'h008, 1'b1, 1'b1, 1'b0, 16'd1});
    vecs.push_back('{1'b0, 2'd0, 32'h000, 1'b1, 1'b1, 32'h010, 1'b1, 1'b1, 1'b0, 16'd1});  // ld_haz x3
    vecs.push_back('{1'b0, 2'd0, 32'h000, 1'b1, 1'b1, 32'h010, 1'b1, 1'b1, 1'b0, 16'd1});
    vecs.push_back('{1'b0, 2'd0, 32'h000, 1'b1, 1'b1, 32'h010, 1'b1, 1'b1, 1'b0, 16'd1});
    vecs.push_back('{1'b0, 2'd0, 32'h000, 1'b0, 1'b1, 32'h010, 1'b1, 1'b1, 1'b0, 16'd1});
    vecs.push_back('{1'b0, 2'd0, 32'h000, 1'b0, 1'b1, 32'h018, 1'b1, 1'b1, 1'b0, 16'd1});
    vecs.push_back('{1'b0, 2'd0, 32'h000, 1'b0, 1'b0, 32'h020, 1'b0, 1'b1, 1'b0, 16'd1});  // mem wait x2
    vecs.push_back('{1'b0, 2'd0, 32'h000, 1'b0, 1'b0, 32'h020, 1'b0, 1'b1, 1'b0, 16'd2});
    vecs.push_back('{1'b0, 2'd0, 32'h000, 1'b0, 1'b1, 32'h020, 1'b1, 1'b1, 1'b0, 16'd3});
    vecs.push_back('{1'b0, 2'd2, 32'h104, 1'b0, 1'b1, 32'h028, 1'b1, 1'b1, 1'b0, 16'd3});  // branch
    vecs.push_back('{1'b0, 2'd0, 32'h000, 1'b0, 1'b1, 32'h104, 1'b0, 1'b0, 1'b1, 16'd3});
    vecs.push_back('{1'b0, 2'd0, 32'h000, 1'b0, 1'b1, 32'h104, 1'b1, 1'b1, 1'b0, 16'd4});
    vecs.push_back('{1'b0, 2'd3, 32'h203, 1'b1, 1'b0, 32'h10C, 1'b0, 1'b1, 1'b0, 16'd4});  // jump beats haz/wait
    vecs.push_back('{1'b0, 2'd0, 32'h000, 1'b0, 1'b1, 32'h200, 1'b0, 1'b0, 1'b1, 16'd5});
    vecs.push_back('{1'b0, 2'd1, 32'h300, 1'b0, 1'b1, 32'h200, 1'b1, 1'b1, 1'b0, 16'd6});  // jalr
    vecs.push_back('{1'b0, 2'd1, 32'h400, 1'b0, 1'b1, 32'h300, 1'b0, 1'b0, 1'b1, 16'd6});  // jalr in FLUSH
    vecs.push_back('{1'b0, 2'd0, 32'h000, 1'b0, 1'b1, 32'h400, 1'b0, 1'b0, 1'b1, 16'd7});
    vecs.push_back('{1'b0, 2'd0, 32'h000, 1'b0, 1'b1, 32'h400, 1'b1, 1'b1, 1'b0, 16'd8});
    vecs.push_back('{1'b0, 2'd0, 32'h000, 1'b0, 1'b0, 32'h408, 1'b0, 1'b1, 1'b0, 16'd8});
    vecs.push_back('{1'b0, 2'd2, 32'h500, 1'b0, 1'b0, 32'h408, 1'b0, 1'b1, 1'b0, 16'd9});  // redirect from HOLD
    vecs.push_back('{1'b0, 2'd0, 32'h000, 1'b0, 1'b1, 32'h500, 1'b0, 1'b0, 1'b1, 16'd10});
    vecs.push_back('{1'b0, 2'd0, 32'h000, 1'b0, 1'b0, 32'h500, 1'b0, 1'b1, 1'b0, 16'd11});
    vecs.push_back('{1'b1, 2'd2, 32'h600, 1'b0, 1'b0, 32'h500, 1'b0, 1'b1, 1'b0, 16'd12}); // reset mid-hold
    vecs.push_back('{1'b0, 2'd3, 32'h700, 1'b0, 1'b1, 32'h000, 1'b0, 1'b0, 1'b0, 16'd0});  // redirect ignored
    vecs.push_back('{1'b0, 2'd0, 32'h000, 1'b0, 1'b1, 32'h000, 1'b1, 1'b1, 1'b0, 16'd1});

    rst = 1'b1; pc_source = 2'd0; jalr_pc = '0; branch_pc = '0; jump_pc = '0;
    ld_haz = 1'b0; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      sb.push_back(vecs[i]);
      @(negedge clk);
      e = sb.pop_front();
      chk($sformatf("row%0d pc0", i), fetch_pc_0, e.pc0);
      chk($sformatf("row%0d pc1", i), fetch_pc_1, e.pc0 + 32'd4);
      chk($sformatf("row%0d valid0", i), {31'b0, fetch_valid_0}, {31'b0, e.vld});
      chk($sformatf("row%0d valid1", i), {31'b0, fetch_valid_1}, {31'b0, e.vld});
      chk($sformatf("row%0d memRead1", i), {31'b0, memRead1}, {31'b0, e.rd});
      chk($sformatf("row%0d squash", i), {31'b0, squash}, {31'b0, e.sq});
      chk($sformatf("row%0d bubbles", i), {16'b0, bubble_count}, {16'b0, e.bub});
      @(posedge clk);
      #1;
    end

    // Wrap: second instance starts at FFFF_FFF8.
    rst = 1'b1; pc_source = 2'd0; ld_haz = 1'b0; mem_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("wrap rst pc0", w_pc_0, 32'hFFFF_FFF8);
    chk("wrap rst rd", {31'b0, w_rd}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("wrap pc0 a", w_pc_0, 32'hFFFF_FFF8);
    chk("wrap pc1 a", w_pc_1, 32'hFFFF_FFFC);
    chk("wrap valid a", {31'b0, w_valid_0}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("wrap pc0 b", w_pc_0, 32'h0000_0000);
    chk("wrap pc1 b", w_pc_1, 32'h0000_0004);

    // Saturation: memory never ready after reset.
    rst = 1'b1; mem_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("sat start", {16'b0, bubble_count}, 32'd0);
    repeat (65534) @(posedge clk);
    @(negedge clk);
    chk("sat FFFE", {16'b0, bubble_count}, 32'h0000_FFFE);
    chk("sat pc held", fetch_pc_0, 32'h0000_0000);
    @(posedge clk);
    @(negedge clk);
    chk("sat FFFF", {16'b0, bubble_count}, 32'h0000_FFFF);
    repeat (4000) @(posedge clk);
    @(negedge clk);
    chk("sat stays", {16'b0, bubble_count}, 32'h0000_FFFF);
    chk("sat memRead1", {31'b0, memRead1}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
